// File: rtl/rs232_fifo_if.sv
// rs232_fifo_if: AQ/WQ/RQ local-I/O handshake shared by the local devices.
// The bus side drives the request; the device answers through the slave modport.
interface rs232_fifo_if;
  logic        read;
  logic [9:0]  wq;
  logic        rwq;
  logic [31:0] rq;
  logic        wrq;
  logic        done;
  logic        selRS232;
  logic        a3;

  modport master (output read, wq, selRS232, a3, input rwq, rq, wrq, done);
  modport slave  (input read, wq, selRS232, a3, output rwq, rq, wrq, done);
endinterface

// File: rtl/rs232_fifo.sv
// rs232_fifo: buffered RS232 port on the local I/O bus.
// RX/TX FIFOs, configurable character length, start-bit glitch rejection,
// sticky framing/overrun flags and a free-running cycle counter.
// Optional macro RS232_PARITY_EN adds a parity bit (parameter evenParity).
module rs232_fifo #(
  parameter int bitTime     = 868,
  parameter int rxDepthLog2 = 4,
  parameter int txDepthLog2 = 4,
  parameter int dataBits    = 8
`ifdef RS232_PARITY_EN
  , parameter int evenParity = 1
`endif
) (
  input  logic           clock,
  input  logic           reset,
  rs232_fifo_if.slave    bus,
  input  logic           RxD,
  output logic           TxD
);

  localparam int CW = (bitTime > 1) ? $clog2(bitTime) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(bitTime - 1);
  localparam logic [CW-1:0] BIT_HALF  = CW'(bitTime / 2);
  localparam logic [2:0]    DATA_LAST = 3'(dataBits - 1);
  localparam int RA = rxDepthLog2;
  localparam int TA = txDepthLog2;
  localparam logic [RA:0] RX_DEPTH = {1'b1, {RA{1'b0}}};
  localparam logic [TA:0] TX_DEPTH = {1'b1, {TA{1'b0}}};
`ifdef RS232_PARITY_EN
  localparam logic PAR_ODD = (evenParity == 0);
`endif

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef RS232_PARITY_EN
    R_PAR,
`endif
    R_STOP, R_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA,
`ifdef RS232_PARITY_EN
    T_PAR,
`endif
    T_STOP
  } tx_state_t;

  // Bus decode: everything is single-cycle and combinational.
  logic wr_cyc, data_wr, err_clr;
  assign wr_cyc   = bus.selRS232 & ~bus.read;
  assign data_wr  = wr_cyc & ~bus.a3;
  assign err_clr  = wr_cyc & bus.a3;
  assign bus.done = bus.selRS232;
  assign bus.wrq  = bus.selRS232 & bus.read;
  assign bus.rwq  = bus.selRS232 & ~bus.read;

  // ---------------------------------------------------------------- state
  logic [31:0]         cycle_counter;
  logic                rx_meta, rx_s;

  logic [dataBits-1:0] tx_mem [2**TA];
  logic [TA:0]         tx_wr, tx_rd;
  logic                tx_empty, tx_full, tx_push, tx_pop;
  logic [dataBits-1:0] tx_head;

  logic [dataBits-1:0] rx_mem [2**RA];
  logic [RA:0]         rx_wr, rx_rd;
  logic                rx_empty, rx_full, rx_pop, rx_store;
  logic [7:0]          rx_head8;

  tx_state_t           tx_state;
  logic [CW-1:0]       tx_cnt;
  logic [2:0]          tx_bit;
  logic [dataBits-1:0] tx_shift;
  logic                tx_tick;

  rx_state_t           rx_state;
  logic [CW-1:0]       rx_cnt;
  logic [2:0]          rx_bit;
  logic [dataBits-1:0] rx_shift;
  logic                rx_tick;
  logic                framing_err, overrun, parity_err;

  // Free-running cycle counter, wraps at 2^32.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_counter <= '0;
    else        cycle_counter <= cycle_counter + 32'd1;
  end

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = ((tx_wr - tx_rd) == TX_DEPTH);
  // Fullness is judged before any same-cycle transmitter pop.
  assign tx_push  = data_wr & bus.wq[9] & ~tx_full;
  assign tx_head  = tx_mem[tx_rd[TA-1:0]];
  assign tx_tick  = (tx_cnt == BIT_LAST);
  assign tx_pop   = ~tx_empty & ((tx_state == T_IDLE) | ((tx_state == T_STOP) & tx_tick));

  // TX storage array.
  // NOTE: FIFO storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr[TA-1:0]] <= bus.wq[dataBits-1:0];
  end

  // TX pointers, one extra bit to tell full from empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = ((rx_wr - rx_rd) == RX_DEPTH);
  assign rx_pop   = data_wr & bus.wq[8] & ~rx_empty;
  assign rx_tick  = (rx_cnt == BIT_LAST);
  // A full FIFO still accepts the character when the head leaves in the same cycle.
  assign rx_store = (rx_state == R_STOP) & rx_tick & rx_s & (~rx_full | rx_pop);

  // RX storage array.
  always_ff @(posedge clock) begin
    if (rx_store) rx_mem[rx_wr[RA-1:0]] <= rx_shift;
  end

  // RX pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_store) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)   rx_rd <= rx_rd + 1'b1;
    end
  end

  // RX head, zero-extended to a byte and forced to 0 when empty.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rx_head8 = '0;
    if (!rx_empty) rx_head8[dataBits-1:0] = rx_mem[rx_rd[RA-1:0]];
  end

  // ---------------------------------------------------------------- transmitter
  // Transmitter FSM; TxD is a registered output forced high by reset.
`ifdef RS232_PARITY_EN
  logic tx_par;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      TxD      <= 1'b1;
`ifdef RS232_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        T_IDLE: begin
          TxD <= 1'b1;
          if (tx_pop) begin
            tx_shift <= tx_head;
`ifdef RS232_PARITY_EN
            tx_par   <= (^tx_head) ^ PAR_ODD;
`endif
            tx_cnt   <= '0;
            TxD      <= 1'b0;
            tx_state <= T_START;
          end
        end
        T_START: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            TxD      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= T_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        T_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == DATA_LAST) begin
`ifdef RS232_PARITY_EN
              TxD      <= tx_par;
              tx_state <= T_PAR;
`else
              TxD      <= 1'b1;
              tx_state <= T_STOP;
`endif
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              TxD      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else tx_cnt <= tx_cnt + 1'b1;
        end
`ifdef RS232_PARITY_EN
        T_PAR: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            TxD      <= 1'b1;
            tx_state <= T_STOP;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
`endif
        T_STOP: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              // Next character follows the stop bit with no idle gap.
              tx_shift <= tx_head;
`ifdef RS232_PARITY_EN
              tx_par   <= (^tx_head) ^ PAR_ODD;
`endif
              TxD      <= 1'b0;
              tx_state <= T_START;
            end else begin
              TxD      <= 1'b1;
              tx_state <= T_IDLE;
            end
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: begin
          TxD      <= 1'b1;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- receiver
  // Receiver FSM with sticky error flags; a clear write loses to a same-cycle set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state    <= R_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef RS232_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      if (err_clr) begin
        framing_err <= 1'b0;
        overrun     <= 1'b0;
`ifdef RS232_PARITY_EN
        parity_err  <= 1'b0;
`endif
      end
      case (rx_state)
        R_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s) rx_state <= R_START;
        end
        R_START: begin
          // Line must still be low half a bit later, otherwise it was a glitch.
          if (rx_cnt == BIT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? R_IDLE : R_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        R_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[dataBits-1:1]};
            if (rx_bit == DATA_LAST) begin
`ifdef RS232_PARITY_EN
              rx_state <= R_PAR;
`else
              rx_state <= R_STOP;
`endif
            end else rx_bit <= rx_bit + 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
`ifdef RS232_PARITY_EN
        R_PAR: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_s != ((^rx_shift) ^ PAR_ODD)) parity_err <= 1'b1;
            rx_state <= R_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
`endif
        R_STOP: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_s) begin
              if (!rx_store) overrun <= 1'b1;
              rx_state <= R_IDLE;
            end else begin
              framing_err <= 1'b1;
              rx_state    <= R_BREAK;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        R_BREAK: begin
          // A held-low line reports one framing error, then waits for idle.
          if (rx_s) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

`ifndef RS232_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Register read mux.
  logic tx_idle;
  assign tx_idle = tx_empty & (tx_state == T_IDLE);
  assign bus.rq  = bus.a3 ? cycle_counter
                          : {18'b0, parity_err, overrun, framing_err, tx_idle,
                             ~tx_full, ~rx_empty, rx_head8};

endmodule
